ext_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one IOb native slave port between two IOb masters: the instruction-cache and data-cache back-ends in front of the external-memory iob2axi bridge. Requests are forwarded with zero added latency when the slave is free. The grant is held until the slave accepts the request. At most one read is outstanding, and its rdata/rvalid is routed back to the master that issued it.

---
 rtl/ext_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_ext_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin share of one IOb slave between two IOb masters.
// m0 = instruction bus, m1 = data bus; one read outstanding at a time.
module ext_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_R
    } state_t;

    state_t state, state_nx;
    logic owner, owner_nx;
    logic prio, prio_nx;

    logic              winner;
    logic              sel;
    logic              sel_avalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              fwd;
    logic              is_write;
    logic              rv;

    // Pick the master to forward: the held owner in HOLD, else the IDLE winner.
    always_comb begin
        winner = m1_avalid_i;
        if (m0_avalid_i && m1_avalid_i) begin
            winner = prio;
        end
        sel        = (state == HOLD) ? owner : winner;
        sel_avalid = sel ? m1_avalid_i : m0_avalid_i;
        sel_addr   = sel ? m1_addr_i : m0_addr_i;
        sel_wdata  = sel ? m1_wdata_i : m0_wdata_i;
        sel_wstrb  = sel ? m1_wstrb_i : m0_wstrb_i;
        fwd        = (state != WAIT_R) && sel_avalid;
        is_write   = |sel_wstrb;
        rv         = (state == WAIT_R) && s_rvalid_i;
    end

    assign s_avalid_o  = fwd;
    assign s_addr_o    = fwd ? sel_addr : '0;
    assign s_wdata_o   = fwd ? sel_wdata : '0;
    assign s_wstrb_o   = fwd ? sel_wstrb : '0;
    assign m0_ready_o  = fwd && !sel && s_ready_i;
    assign m1_ready_o  = fwd && sel && s_ready_i;
    assign m0_rvalid_o = rv && !owner;
    assign m1_rvalid_o = rv && owner;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

    // Next state, owner and tie-break priority.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        prio_nx  = prio;
        unique case (state)
            IDLE: begin
                if (fwd) begin
                    if (s_ready_i) begin
                        prio_nx = ~sel;
                        if (!is_write) begin
                            owner_nx = sel;
                            state_nx = WAIT_R;
                        end
                    end else begin
                        owner_nx = sel;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!fwd) begin
                    state_nx = IDLE;
                end else if (s_ready_i) begin
                    prio_nx  = ~owner;
                    state_nx = is_write ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (s_rvalid_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State registers; frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else if (cke_i) begin
            state <= state_nx;
            owner <= owner_nx;
            prio  <= prio_nx;
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed vectors plus a transaction-level model
// compared against the arbiter outputs every cycle.
module tb_ext_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          arst_n_i;
    logic          cke_i;
    logic          av [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [SW-1:0] wstrb [2];
    logic          rdy [2];
    logic          rvalid [2];
    logic [DW-1:0] rdata [2];
    logic          s_avalid_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o;
    logic [SW-1:0] s_wstrb_o;
    logic          s_ready_i;
    logic          s_rvalid_i;
    logic [DW-1:0] s_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ext_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .m0_avalid_i(av[0]),
        .m0_addr_i  (addr[0]),
        .m0_wdata_i (wdata[0]),
        .m0_wstrb_i (wstrb[0]),
        .m0_ready_o (rdy[0]),
        .m0_rvalid_o(rvalid[0]),
        .m0_rdata_o (rdata[0]),
        .m1_avalid_i(av[1]),
        .m1_addr_i  (addr[1]),
        .m1_wdata_i (wdata[1]),
        .m1_wstrb_i (wstrb[1]),
        .m1_ready_o (rdy[1]),
        .m1_rvalid_o(rvalid[1]),
        .m1_rdata_o (rdata[1]),
        .s_avalid_o (s_avalid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: who holds the grant, who has a read in
    // flight (-1 = nobody) and which master wins the next tie.
    int m_lock = -1;
    int m_rd   = -1;
    int m_prio = 0;

    function automatic int pick();
        if (m_lock >= 0) return m_lock;
        if (av[0] && av[1]) return m_prio;
        if (av[1]) return 1;
        if (av[0]) return 0;
        return -1;
    endfunction

    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            m_lock <= -1;
            m_rd   <= -1;
            m_prio <= 0;
        end else if (cke_i) begin
            if (m_rd >= 0) begin
                if (s_rvalid_i) m_rd <= -1;
            end else begin
                int g;
                g = pick();
                if (g >= 0 && av[g]) begin
                    if (s_ready_i) begin
                        m_prio <= 1 - g;
                        m_lock <= -1;
                        if (wstrb[g] == '0) m_rd <= g;
                    end else begin
                        m_lock <= g;
                    end
                end else begin
                    m_lock <= -1;
                end
            end
        end
    end

    // Compare every cycle against the model, away from the rising edge.
    always @(negedge clk_i) begin
        logic          e_sav;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [SW-1:0] e_ws;
        logic          e_rdy [2];
        logic          e_rv [2];
        logic [DW-1:0] e_rd [2];
        int            g;
        e_sav = 0; e_addr = 0; e_wd = 0; e_ws = 0;
        e_rdy[0] = 0; e_rdy[1] = 0;
        e_rv[0] = 0; e_rv[1] = 0;
        e_rd[0] = 0; e_rd[1] = 0;
        if (m_rd >= 0) begin
            e_rv[m_rd] = s_rvalid_i;
            e_rd[m_rd] = s_rvalid_i ? s_rdata_i : '0;
        end else begin
            g = pick();
            if (g >= 0 && av[g]) begin
                e_sav    = 1;
                e_addr   = addr[g];
                e_wd     = wdata[g];
                e_ws     = wstrb[g];
                e_rdy[g] = s_ready_i;
            end
        end
        check("model s_avalid", 64'(s_avalid_o), 64'(e_sav));
        check("model s_addr", 64'(s_addr_o), 64'(e_addr));
        check("model s_wdata", 64'(s_wdata_o), 64'(e_wd));
        check("model s_wstrb", 64'(s_wstrb_o), 64'(e_ws));
        check("model m0_ready", 64'(rdy[0]), 64'(e_rdy[0]));
        check("model m1_ready", 64'(rdy[1]), 64'(e_rdy[1]));
        check("model m0_rvalid", 64'(rvalid[0]), 64'(e_rv[0]));
        check("model m1_rvalid", 64'(rvalid[1]), 64'(e_rv[1]));
        check("model m0_rdata", 64'(rdata[0]), 64'(e_rd[0]));
        check("model m1_rdata", 64'(rdata[1]), 64'(e_rd[1]));
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            av[i] = 0; addr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
        end
        s_ready_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
        cke_i = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst_n_i = 0;
        cyc();
        cyc();
        arst_n_i = 1;
        cyc();
    endtask

    task automatic req(input int m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        av[m] = 1; addr[m] = a; wdata[m] = d; wstrb[m] = s;
    endtask

    initial begin
        idle_inputs();
        arst_n_i = 0;
        // Reset: outputs quiet, stray rvalid ignored.
        s_rvalid_i = 1; s_rdata_i = 32'hCAFEF00D;
        cyc();
        #1;
        check("rst s_avalid", 64'(s_avalid_o), 0);
        check("rst rvalid", 64'({rvalid[0], rvalid[1]}), 0);
        check("rst rdata", 64'(rdata[0] | rdata[1]), 0);
        check("rst s_addr", 64'(s_addr_o), 0);
        do_reset();

        // Single read from m1 with 3-cycle slave latency.
        req(1, 32'h100, 0, 0); s_ready_i = 1;
        #1;
        check("rd m1_ready", 64'(rdy[1]), 1);
        check("rd s_addr", 64'(s_addr_o), 64'h100);
        cyc();
        av[1] = 0; s_ready_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rd wait rvalid", 64'(rvalid[1]), 0);
            check("rd wait ready", 64'(rdy[1]), 0);
            cyc();
        end
        s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
        #1;
        check("rd m1_rvalid", 64'(rvalid[1]), 1);
        check("rd m1_rdata", 64'(rdata[1]), 64'hDEADBEEF);
        check("rd m0_rvalid", 64'(rvalid[0]), 0);
        cyc();
        s_rvalid_i = 0;
        cyc();

        // Tie and rotation with back-to-back writes.
        do_reset();
        req(0, 32'hA0, 32'h11, 4'hF);
        req(1, 32'hB0, 32'h22, 4'hF);
        s_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rot m0_ready", 64'(rdy[0]), 64'(i % 2 == 0));
            check("rot m1_ready", 64'(rdy[1]), 64'(i % 2 == 1));
            check("rot s_addr", 64'(s_addr_o),
                  (i % 2 == 0) ? 64'hA0 : 64'hB0);
            cyc();
        end

        // Hold: m0 write stalled 4 cycles while m1 waits.
        do_reset();
        req(0, 32'hC0, 32'h55, 4'hF);
        req(1, 32'hD0, 32'h66, 4'h3);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hold s_addr", 64'(s_addr_o), 64'hC0);
            check("hold s_wdata", 64'(s_wdata_o), 64'h55);
            check("hold m1_ready", 64'(rdy[1]), 0);
            cyc();
        end
        s_ready_i = 1;
        #1;
        check("hold c5 m0_ready", 64'(rdy[0]), 1);
        check("hold c5 m1_ready", 64'(rdy[1]), 0);
        cyc();
        av[0] = 0;
        #1;
        check("hold c6 m1_ready", 64'(rdy[1]), 1);
        check("hold c6 s_addr", 64'(s_addr_o), 64'hD0);
        cyc();
        av[1] = 0;
        cyc();

        // Outstanding read blocks the other master.
        do_reset();
        req(0, 32'h200, 0, 0); s_ready_i = 1;
        cyc();
        av[0] = 0;
        req(1, 32'h300, 32'h77, 4'hF);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("blk s_avalid", 64'(s_avalid_o), 0);
            check("blk m1_ready", 64'(rdy[1]), 0);
            cyc();
        end
        s_rvalid_i = 1; s_rdata_i = 32'h12345678;
        #1;
        check("blk m0_rvalid", 64'(rvalid[0]), 1);
        check("blk rv s_avalid", 64'(s_avalid_o), 0);
        cyc();
        s_rvalid_i = 0;
        #1;
        check("blk after s_avalid", 64'(s_avalid_o), 1);
        check("blk after s_addr", 64'(s_addr_o), 64'h300);
        check("blk after m1_ready", 64'(rdy[1]), 1);
        cyc();
        av[1] = 0;
        cyc();

        // Reset during an outstanding read; late rvalid is dropped.
        do_reset();
        req(1, 32'h400, 0, 0); s_ready_i = 1;
        cyc();
        av[1] = 0; s_ready_i = 0;
        #2;
        arst_n_i = 0;
        cyc();
        arst_n_i = 1;
        cyc();
        s_rvalid_i = 1; s_rdata_i = 32'hBAD0BAD0;
        #1;
        check("rstw rvalid", 64'({rvalid[0], rvalid[1]}), 0);
        check("rstw rdata", 64'(rdata[0] | rdata[1]), 0);
        check("rstw s_avalid", 64'(s_avalid_o), 0);
        cyc();
        s_rvalid_i = 0;
        req(0, 32'hE0, 32'h1, 4'h1);
        req(1, 32'hF0, 32'h2, 4'h1);
        s_ready_i = 1;
        #1;
        check("rstw tie m0_ready", 64'(rdy[0]), 1);
        check("rstw tie m1_ready", 64'(rdy[1]), 0);
        cyc();
        idle_inputs();
        cyc();

        // Clock enable low while a read is outstanding.
        do_reset();
        req(1, 32'h500, 0, 0); s_ready_i = 1;
        cyc();
        av[1] = 0;
        cke_i = 0;
        req(0, 32'h600, 32'h9, 4'hF);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cke s_avalid", 64'(s_avalid_o), 0);
            cyc();
        end
        cke_i = 1; av[0] = 0;
        s_rvalid_i = 1; s_rdata_i = 32'h0BADF00D;
        #1;
        check("cke m1_rvalid", 64'(rvalid[1]), 1);
        check("cke m1_rdata", 64'(rdata[1]), 64'h0BADF00D);
        cyc();
        #1;
        check("cke late rvalid", 64'(rvalid[1]), 0);
        cyc();
        s_rvalid_i = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
